flash_apb_ctrl: RTL
===================

// Module: flash_apb_ctrl
// PURPOSE
// - APB completer for the flash subsystem. Responds to transfers issued by the AHB-to-APB bridge.
// - Holds the flash command registers and runs the program/erase sequencer.
// - Drives the flash_we, flash_erase, flash_addr and flash_wdata strobes with the timing set by the parameters.
// - Inserts APB wait states and flags illegal accesses with pslverr.
// PARAMETERS
// - WAIT_STATES   1   pready low cycles in the access phase (0..15)
// - PROG_CYCLES   8   cycles flash_we is held per program op (>=1)
// - ERASE_CYCLES  32  cycles flash_erase is held per erase op (>=1)
// PORTS
// - clk          in   1   single clock, all logic on posedge
// - rst          in   1   asynchronous reset, active-high
// - paddr        in   32  APB address; only [4:2] decoded, [1:0] ignored
// - pwdata       in   32  APB write data
// - pwrite       in   1   1=write, 0=read
// - psel         in   1   APB select
// - penable      in   1   APB access phase
// - prdata       out  32  read data, valid when pready=1
// - pready       out  1   transfer complete
// - pslverr      out  1   error response, valid when pready=1
// - flash_we     out  1   program strobe
// - flash_erase  out  1   erase strobe
// - flash_addr   out  32  flash target address (ADDR reg)
// - flash_wdata  out  32  flash program data (WDATA reg)
// - flash_rdata  in   32  flash read data, sampled on RDATA reads
// - irq          out  1   completion interrupt (see CONFIGURATION)
// BEHAVIOUR
// - Reset: all outputs and registers 0, FSM=IDLE, wait counter=0. A reset mid-op aborts it; strobes drop asynchronously.
// - Register map (paddr[4:2]):
//   - 0 CTRL: W-only. b0 START_PROG and b1 START_ERASE self-clear. b2 IE is stored. Read returns {29'b0,IE,2'b0}.
//   - 1 ADDR: R/W.
//   - 2 WDATA: R/W.
//   - 3 STATUS: b0 BUSY, b1 DONE (sticky, W1C), b2 ERR (sticky, W1C).
//   - 4 RDATA: R-only; returns flash_rdata sampled in the completing cycle.
//   - 5..7: unmapped.
// - APB handshake:
//   - Setup phase is psel=1 & penable=0. The access phase starts on the next cycle.
//   - pready=0 for WAIT_STATES access cycles, then 1 for exactly one cycle. WAIT_STATES=0 gives pready=1 in the first access cycle.
//   - Register update and prdata/pslverr are presented only in the cycle psel&penable&pready.
//   - pready, pslverr and prdata return to 0 in the following cycle.
//   - psel dropping mid-access aborts the transfer with no register effect and resets the wait counter.
// - pslverr=1 (write ignored, prdata=0) for:
//   - any unmapped address;
//   - a write to RDATA;
//   - a write to ADDR, WDATA or CTRL while BUSY, except a CTRL write with b0=b1=0, which updates IE only;
//   - START_PROG and START_ERASE both 1 in one write. This also sets ERR.
// - FSM IDLE -> PROG | ERASE -> IDLE:
//   - START_PROG in IDLE: the cycle after completion, BUSY=1 and flash_we=1 for PROG_CYCLES cycles.
//   - START_ERASE: same, with flash_erase=1 for ERASE_CYCLES cycles.
//   - Down-counter width is $clog2(max cycles)+1. The last strobe cycle is the one with counter=1.
//   - The next cycle: strobe=0, BUSY=0, DONE=1, FSM=IDLE.
//   - flash_addr and flash_wdata always mirror ADDR and WDATA. Both are frozen while BUSY because writes are refused.
// - flash_we and flash_erase are never both 1.
// - Simultaneous DONE set and a W1C of DONE: set wins.
// CONFIGURATION
// - FLASH_APB_IRQ_EN defined: irq is registered, irq = DONE & IE. It rises one cycle after DONE sets and clears when DONE is cleared or IE=0.
// - FLASH_APB_IRQ_EN undefined: IE bit reads 0 and is not stored; irq is tied to 0.
// TESTING
// - Reset: rst pulse mid-PROG with flash_we=1 -> flash_we=0 immediately, STATUS reads 0x0, pready=0.
// - Wait states: WAIT_STATES=2, write ADDR=0x0000_0040 -> pready high on the 3rd access cycle; readback returns 0x40 with pslverr=0.
// - Program: ADDR=0x10, WDATA=0xDEADBEEF, CTRL=0x1 -> flash_we=1 for exactly 8 cycles with flash_addr=0x10 and flash_wdata=0xDEADBEEF; then STATUS=0x2.
// - Busy errors: during ERASE, write WDATA=0x1 -> pslverr=1 and WDATA unchanged; STATUS reads 0x1; flash_erase stays high for a full 32 cycles.
// - Illegal: CTRL=0x3 -> pslverr=1 and STATUS=0x4. Read paddr=0x18 -> pslverr=1, prdata=0. Write STATUS=0x6 -> STATUS=0x0.
// - IRQ (macro on): CTRL=0x5 -> irq=1 one cycle after DONE sets; write STATUS=0x2 -> irq=0. Macro off: irq stays 0 throughout.

Source files
------------

// File: rtl/flash_apb_ctrl_if.sv
// APB bus bundle between the AHB-to-APB bridge (master) and flash_apb_ctrl (slave).
interface flash_apb_ctrl_if;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output paddr, pwdata, pwrite, psel, penable,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, pwdata, pwrite, psel, penable,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/flash_apb_ctrl.sv
// APB completer holding the flash command registers and the program/erase sequencer.
// Optional completion interrupt enabled by defining FLASH_APB_IRQ_EN.
module flash_apb_ctrl #(
    parameter int unsigned WAIT_STATES  = 1,
    parameter int unsigned PROG_CYCLES  = 8,
    parameter int unsigned ERASE_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    flash_apb_ctrl_if.slave   apb,
    output logic              flash_we,
    output logic              flash_erase,
    output logic [31:0]       flash_addr,
    output logic [31:0]       flash_wdata,
    input  logic [31:0]       flash_rdata,
    output logic              irq
);
    localparam int unsigned MaxCycles = (PROG_CYCLES > ERASE_CYCLES) ? PROG_CYCLES : ERASE_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles) + 1;
    localparam logic [3:0]  WaitLast  = 4'(WAIT_STATES);

    typedef enum logic [1:0] {StIdle, StProg, StErase} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [3:0]      wait_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic            done_q;
    logic            err_q;
    logic            ie;

    logic        access;
    logic        busy;
    logic        slverr;
    logic        wr_ok;
    logic        ctrl_wr;
    logic        status_wr;
    logic        set_err;
    logic        done_set;
    logic [2:0]  idx;
    logic [31:0] rdata_mux;
    logic        unused;

    assign idx    = apb.paddr[4:2];
    assign busy   = (state_q != StIdle);
    assign access = apb.psel & apb.penable;
    assign unused = ^{apb.paddr[31:5], apb.paddr[1:0]};

    assign apb.pready  = access & (wait_q == WaitLast);
    assign apb.pslverr = apb.pready & slverr;
    assign apb.prdata  = (apb.pready && !slverr && !apb.pwrite) ? rdata_mux : '0;

    always_comb begin
        slverr    = 1'b0;
        rdata_mux = '0;
        case (idx)
            3'd0: begin
                rdata_mux = {29'b0, ie, 2'b0};
                // A CTRL write with no start bits only touches IE, so it is legal while busy.
                if (apb.pwrite && ((apb.pwdata[1:0] == 2'b11) || (busy && |apb.pwdata[1:0]))) begin
                    slverr = 1'b1;
                end
            end
            3'd1: begin
                rdata_mux = addr_q;
                slverr    = apb.pwrite & busy;
            end
            3'd2: begin
                rdata_mux = wdata_q;
                slverr    = apb.pwrite & busy;
            end
            3'd3: rdata_mux = {29'b0, err_q, done_q, busy};
            3'd4: begin
                rdata_mux = flash_rdata;
                slverr    = apb.pwrite;
            end
            default: slverr = 1'b1;
        endcase
    end

    assign wr_ok     = apb.pready & apb.pwrite & ~slverr;
    assign ctrl_wr   = wr_ok & (idx == 3'd0);
    assign status_wr = wr_ok & (idx == 3'd3);
    assign set_err   = apb.pready & apb.pwrite & (idx == 3'd0) & (apb.pwdata[1:0] == 2'b11);
    assign done_set  = busy & (cnt_q == CntW'(1));

    assign flash_addr  = addr_q;
    assign flash_wdata = wdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            wait_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            flash_we    <= 1'b0;
            flash_erase <= 1'b0;
        end else begin
            // Counter also clears when psel drops, aborting the transfer.
            if (access && !apb.pready) wait_q <= wait_q + 4'd1;
            else                       wait_q <= '0;

            if (wr_ok && idx == 3'd1) addr_q  <= apb.pwdata;
            if (wr_ok && idx == 3'd2) wdata_q <= apb.pwdata;

            if (set_err)                         err_q <= 1'b1;
            else if (status_wr && apb.pwdata[2]) err_q <= 1'b0;

            if (done_set)                        done_q <= 1'b1;
            else if (status_wr && apb.pwdata[1]) done_q <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (ctrl_wr && apb.pwdata[0]) begin
                        state_q  <= StProg;
                        cnt_q    <= CntW'(PROG_CYCLES);
                        flash_we <= 1'b1;
                    end else if (ctrl_wr && apb.pwdata[1]) begin
                        state_q     <= StErase;
                        cnt_q       <= CntW'(ERASE_CYCLES);
                        flash_erase <= 1'b1;
                    end
                end
                StProg, StErase: begin
                    if (done_set) begin
                        state_q     <= StIdle;
                        flash_we    <= 1'b0;
                        flash_erase <= 1'b0;
                    end
                    cnt_q <= cnt_q - CntW'(1);
                end
                default: begin
                    state_q     <= StIdle;
                    flash_we    <= 1'b0;
                    flash_erase <= 1'b0;
                end
            endcase
        end
    end

`ifdef FLASH_APB_IRQ_EN
    logic ie_q;

    assign ie = ie_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ie_q <= 1'b0;
            irq  <= 1'b0;
        end else begin
            if (ctrl_wr) ie_q <= apb.pwdata[2];
            irq <= done_q & ie_q;
        end
    end
`else
    assign ie  = 1'b0;
    assign irq = 1'b0;
`endif
endmodule
